// File: rtl/param_checker.sv
// Parameter checker: after a settle delay, compares six observed values against
// their expected parameter values over SAMPLES passes and reports a sticky mismatch mask.
module param_checker #(
  parameter int          BOO      = 1,
  parameter int          INT      = 1,
  parameter logic        LOG      = 1'b1,
  parameter logic [7:0]  VEC      = 8'd1,
  parameter logic        STR_FLAG = 1'b1,
  parameter logic        REA_FLAG = 1'b1,
  parameter int          SETTLE   = 4,
  parameter int          SAMPLES  = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       boo_i,
  input  logic [7:0] int_i,
  input  logic       log_i,
  input  logic [7:0] vec_i,
  input  logic       str_i,
  input  logic       rea_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       pass_o,
  output logic [5:0] err_o
);

  // A SETTLE of zero still spends one cycle settling.
  localparam int         SETTLE_N  = (SETTLE < 1) ? 1 : SETTLE;
  localparam int         SW        = $clog2(SETTLE_N + 1);
  localparam logic       BOO_B     = BOO[0];
  localparam logic [7:0] INT_B     = INT[7:0];
  localparam logic [7:0] LAST_PASS = 8'(SAMPLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETTLING,
    CHECK,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] settleCnt_q, settleCnt_d;
  logic [2:0]    fieldIdx_q, fieldIdx_d;
  logic [7:0]    passCnt_q, passCnt_d;
  logic [5:0]    err_q, err_d;
  logic          pass_q, pass_d;
  logic          mismatch;

  always_comb begin
    mismatch = 1'b0;
    case (fieldIdx_q)
      3'd0:    mismatch = (boo_i != BOO_B);
      3'd1:    mismatch = (int_i != INT_B);
      3'd2:    mismatch = (log_i != LOG);
      3'd3:    mismatch = (vec_i != VEC);
      3'd4:    mismatch = (str_i != STR_FLAG);
      3'd5:    mismatch = (rea_i != REA_FLAG);
      default: mismatch = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    settleCnt_d = settleCnt_q;
    fieldIdx_d  = fieldIdx_q;
    passCnt_d   = passCnt_q;
    err_d       = err_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d     = SETTLING;
          settleCnt_d = SW'(SETTLE_N);
          fieldIdx_d  = 3'd0;
          passCnt_d   = 8'd0;
          err_d       = 6'd0;
        end
      end
      SETTLING: begin
        if (settleCnt_q == SW'(1)) begin
          state_d     = CHECK;
          settleCnt_d = '0;
        end else begin
          settleCnt_d = settleCnt_q - SW'(1);
        end
      end
      CHECK: begin
        if (mismatch) err_d[fieldIdx_q] = 1'b1;
        if (fieldIdx_q == 3'd5) begin
          fieldIdx_d = 3'd0;
          if (passCnt_q < LAST_PASS) begin
            passCnt_d = passCnt_q + 8'd1;
          end else begin
            state_d = DONE;
          end
        end else begin
          fieldIdx_d = fieldIdx_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pass is decided from the next-state mask so it appears together with DONE.
  assign pass_d = (state_d == DONE) && (err_d == 6'd0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      settleCnt_q <= '0;
      fieldIdx_q  <= 3'd0;
      passCnt_q   <= 8'd0;
      err_q       <= 6'd0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      settleCnt_q <= settleCnt_d;
      fieldIdx_q  <= fieldIdx_d;
      passCnt_q   <= passCnt_d;
      err_q       <= err_d;
      pass_q      <= pass_d;
    end
  end

  assign busy_o = (state_q == SETTLING) || (state_q == CHECK);
  assign done_o = (state_q == DONE);
  assign pass_o = pass_q;
  assign err_o  = err_q;

endmodule

// File: tb/tb_param_checker.sv
// Directed bench for param_checker: four instances with different parameter sets,
// each exercised one at a time against hand-computed expectations.
module tb_param_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start [4];
  logic       booIn = 1'b1;
  logic [7:0] intIn = 8'd1;
  logic       logIn = 1'b1;
  logic [7:0] vecIn = 8'd1;
  logic       strIn = 1'b1;
  logic       reaIn = 1'b1;
  logic       busy [4];
  logic       done [4];
  logic       pass [4];
  logic [5:0] err  [4];

  int vecCount  = 0;
  int missCount = 0;

  always #5 clk = ~clk;

  // dut 0: defaults; dut 1: INT=300; dut 2: SAMPLES=3; dut 3: SETTLE=0
  param_checker dutDefault (
    .clk_i(clk), .rst_i(rst), .start_i(start[0]),
    .boo_i(booIn), .int_i(intIn), .log_i(logIn), .vec_i(vecIn), .str_i(strIn), .rea_i(reaIn),
    .busy_o(busy[0]), .done_o(done[0]), .pass_o(pass[0]), .err_o(err[0])
  );

  param_checker #(.INT(300)) dutInt300 (
    .clk_i(clk), .rst_i(rst), .start_i(start[1]),
    .boo_i(booIn), .int_i(intIn), .log_i(logIn), .vec_i(vecIn), .str_i(strIn), .rea_i(reaIn),
    .busy_o(busy[1]), .done_o(done[1]), .pass_o(pass[1]), .err_o(err[1])
  );

  param_checker #(.SAMPLES(3)) dutSamples3 (
    .clk_i(clk), .rst_i(rst), .start_i(start[2]),
    .boo_i(booIn), .int_i(intIn), .log_i(logIn), .vec_i(vecIn), .str_i(strIn), .rea_i(reaIn),
    .busy_o(busy[2]), .done_o(done[2]), .pass_o(pass[2]), .err_o(err[2])
  );

  param_checker #(.SETTLE(0)) dutSettle0 (
    .clk_i(clk), .rst_i(rst), .start_i(start[3]),
    .boo_i(booIn), .int_i(intIn), .log_i(logIn), .vec_i(vecIn), .str_i(strIn), .rea_i(reaIn),
    .busy_o(busy[3]), .done_o(done[3]), .pass_o(pass[3]), .err_o(err[3])
  );

  task automatic checkOutput(input string tag, input int got, input int exp);
    vecCount++;
    if (got != exp) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic b, input logic [7:0] iv, input logic l,
                               input logic [7:0] v, input logic s, input logic r);
    booIn = b; intIn = iv; logIn = l; vecIn = v; strIn = s; reaIn = r;
  endtask

  // Advance one clock and land 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count samples with busy high, starting at the current (post-start) sample.
  task automatic countBusy(input int k, output int n);
    n = 0;
    while (busy[k] && n < 100) begin
      n++;
      tick();
    end
  endtask

  task automatic pulseStart(input int k);
    start[k] = 1'b1;
    tick();
    start[k] = 1'b0;
  endtask

  task automatic checkAll(input string tag, input int k, input logic b, input logic d,
                          input logic p, input logic [5:0] e);
    checkOutput({tag, " busy"}, int'(busy[k]), int'(b));
    checkOutput({tag, " done"}, int'(done[k]), int'(d));
    checkOutput({tag, " pass"}, int'(pass[k]), int'(p));
    checkOutput({tag, " err"},  int'(err[k]),  int'(e));
  endtask

  initial begin
    int n;
    for (int i = 0; i < 4; i++) start[i] = 1'b0;
    applyStimulus(1'b1, 8'd1, 1'b1, 8'd1, 1'b1, 1'b1);
    repeat (3) tick();
    checkAll("reset", 0, 1'b0, 1'b0, 1'b0, 6'h00);
    rst = 1'b0;
    repeat (5) tick();
    checkAll("idle after reset", 0, 1'b0, 1'b0, 1'b0, 6'h00);

    // Defaults, everything matching
    pulseStart(0);
    countBusy(0, n);
    checkOutput("default busy cycles", n, 16);
    checkAll("default done", 0, 1'b0, 1'b1, 1'b1, 6'h00);
    repeat (3) tick();
    checkOutput("default done hold", int'(done[0]), 1);

    // INT=300 compares mod 256 -> 44
    applyStimulus(1'b1, 8'd44, 1'b1, 8'd1, 1'b1, 1'b1);
    pulseStart(1);
    countBusy(1, n);
    checkOutput("int300 busy cycles", n, 16);
    checkAll("int300 done", 1, 1'b0, 1'b1, 1'b1, 6'h00);

    // VEC and STR mismatches, restart from DONE
    applyStimulus(1'b1, 8'd1, 1'b1, 8'd2, 1'b0, 1'b1);
    pulseStart(0);
    checkAll("restart edge", 0, 1'b1, 1'b0, 1'b0, 6'h00);
    countBusy(0, n);
    checkOutput("vecstr busy cycles", n, 16);
    checkAll("vecstr done", 0, 1'b0, 1'b1, 1'b0, 6'h18);

    // SAMPLES=3, LOG glitch only in pass 1 index 2 (sampled at edge 13 after start)
    applyStimulus(1'b1, 8'd1, 1'b1, 8'd1, 1'b1, 1'b1);
    pulseStart(2);
    n = 0;
    while (busy[2] && n < 100) begin
      n++;
      logIn = (n == 13) ? 1'b0 : 1'b1;
      tick();
    end
    logIn = 1'b1;
    checkOutput("samples3 busy cycles", n, 22);
    checkAll("samples3 done", 2, 1'b0, 1'b1, 1'b0, 6'h04);

    // SETTLE=0 with start held high: 13 busy, one DONE cycle, then rerun
    start[3] = 1'b1;
    tick();
    countBusy(3, n);
    checkOutput("settle0 busy cycles", n, 13);
    checkAll("settle0 done", 3, 1'b0, 1'b1, 1'b1, 6'h00);
    tick();
    checkAll("settle0 rerun", 3, 1'b1, 1'b0, 1'b0, 6'h00);
    start[3] = 1'b0;

    // Asynchronous reset mid-CHECK with a VEC mismatch already captured
    applyStimulus(1'b1, 8'd1, 1'b1, 8'd2, 1'b1, 1'b1);
    pulseStart(0);
    repeat (9) tick();
    checkAll("midcheck", 0, 1'b1, 1'b0, 1'b0, 6'h08);
    #2 rst = 1'b1;
    #1;
    checkAll("async reset", 0, 1'b0, 1'b0, 1'b0, 6'h00);
    rst = 1'b0;
    applyStimulus(1'b1, 8'd1, 1'b1, 8'd1, 1'b1, 1'b1);
    repeat (4) tick();
    checkAll("idle after midreset", 0, 1'b0, 1'b0, 1'b0, 6'h00);
    pulseStart(0);
    countBusy(0, n);
    checkOutput("post reset busy cycles", n, 16);
    checkAll("post reset done", 0, 1'b0, 1'b1, 1'b1, 6'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
